// File: rtl/single_port_ram_arbiter.sv
// single_port_ram_arbiter
// Two-requester arbiter/sequencer in front of one single-port RAM
// (en=1 write, en=0 read, read data valid the cycle after the read edge).
// Commands from A and B are serialised onto the RAM port; read data is
// returned to the issuing requester with a one-cycle valid pulse.
//
// Build option:
//   ARB_FIXED_PRIO_EN - when defined, A always wins a tie (fixed priority)
//                       and the round-robin pointer is not built.
//                       Default (undefined): round-robin, A wins first tie.
// Timing is identical in both builds.

module single_port_ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   owner_b;   // requester that owns the command in flight
    logic   pick_b;    // arbitration result for the current IDLE sample

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: B only wins when A is not requesting.
    assign pick_b = b_req && !a_req;
`else
    logic last_b;      // 1: B was granted last, so A wins the next tie

    // Round robin: on a tie, the requester not granted last wins.
    assign pick_b = b_req && (!a_req || !last_b);
`endif

    // Sequencer: IDLE samples requests, ISSUE drives the RAM for one edge,
    // RESP routes the RAM read data back to the owning requester.
    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge value of every other register, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner_b  <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            ram_en   <= 1'b0;
            ram_adr  <= '0;
            ram_data <= '0;
            busy     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_b   <= 1'b1;
`endif
        end else begin
            // Pulses default low; only the cases below raise them.
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    ram_en <= 1'b0;
                    if (a_req || b_req) begin
                        owner_b <= pick_b;
                        if (pick_b) begin
                            ram_en   <= b_we;
                            ram_adr  <= b_adr;
                            ram_data <= b_data;
                            b_gnt    <= 1'b1;
                        end else begin
                            ram_en   <= a_we;
                            ram_adr  <= a_adr;
                            ram_data <= a_data;
                            a_gnt    <= 1'b1;
                        end
`ifndef ARB_FIXED_PRIO_EN
                        last_b <= pick_b;
`endif
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end

                ISSUE: begin
                    // The RAM acts on the edge ending this cycle; a write is
                    // then complete, a read still needs its data cycle.
                    ram_en <= 1'b0;
                    if (ram_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RESP;
                    end
                end

                RESP: begin
                    // ram_out now holds the read data; only the owner's
                    // rdata register is touched.
                    if (owner_b) begin
                        b_rdata  <= ram_out;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= ram_out;
                        a_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    ram_en <= 1'b0;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// tb_single_port_ram_arbiter
// Self-checking bench: a behavioural RAM model on the RAM port, directed
// scenarios plus randomized traffic, each cycle compared against a
// transaction-timeline reference model (grant at +1, write done after the
// grant cycle, read data valid at +2 after the grant).

module tb_single_port_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_adr = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_adr = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_en, busy;
    logic [DW-1:0] a_rdata, b_rdata, ram_data;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_out = '0;

    single_port_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_data(a_data),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_data(b_data),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_adr(ram_adr), .ram_data(ram_data),
        .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: synchronous write, registered read.
    logic [DW-1:0] mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en) mem[ram_adr] <= ram_data;
        ram_out <= mem[ram_adr];
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t a_q[$], b_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    int            next_sample;
    int            rv_at;
    bit            rv_b;
    logic [DW-1:0] rv_data;
    bit            last_winner_b;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_a_rdata, exp_b_rdata, exp_ram_data;
    logic [AW-1:0] exp_ram_adr;

    int            gnt_log[$];
    logic [DW-1:0] rd_log[$];
    int            a_gnt_cnt;

    function automatic logic [35:0] outs();
        return {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en, busy,
                ram_adr, ram_data, a_rdata, b_rdata};
    endfunction

    function automatic cmd_t mk(input logic we, input int adr, input int data);
        cmd_t c;
        c.we = we; c.adr = AW'(adr); c.data = DW'(data);
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        int sel;
        int adr;
        sel = $urandom_range(0, 3);
        adr = (sel == 0) ? 0 : (sel == 1) ? 63 : $urandom_range(0, 15);
        return mk(1'($urandom_range(0, 1)), adr, $urandom_range(0, 255));
    endfunction

    task automatic model_reset();
        last_winner_b = 1'b1;
        next_sample   = 0;
        rv_at         = -1;
        exp_a_rdata   = '0;
        exp_b_rdata   = '0;
        exp_ram_adr   = '0;
        exp_ram_data  = '0;
    endtask

    task automatic drive_reqs();
        if (a_q.size() > 0) begin
            a_req = 1'b1; a_we = a_q[0].we; a_adr = a_q[0].adr; a_data = a_q[0].data;
        end else a_req = 1'b0;
        if (b_q.size() > 0) begin
            b_req = 1'b1; b_we = b_q[0].we; b_adr = b_q[0].adr; b_data = b_q[0].data;
        end else b_req = 1'b0;
    endtask

    // Runs queued (and optionally random) traffic until everything drains.
    task automatic run(input int max_cycles, input int rnd_cycles);
        int   start;
        bit   done;
        bit   ea_gnt, eb_gnt, ea_rv, eb_rv, e_en, e_busy, win_b;
        cmd_t c;
        logic [35:0] got, expv;
        start = cyc;
        done  = 1'b0;
        while (!done) begin
            if (cyc - start < rnd_cycles) begin
                if (a_q.size() == 0 && $urandom_range(0, 2) != 0) a_q.push_back(rand_cmd());
                if (b_q.size() == 0 && $urandom_range(0, 2) != 0) b_q.push_back(rand_cmd());
            end
            drive_reqs();
            @(posedge clk); #1; cyc++;

            {ea_gnt, eb_gnt, ea_rv, eb_rv, e_en} = '0;
            if (cyc >= next_sample && (a_req || b_req)) begin
`ifdef ARB_FIXED_PRIO_EN
                win_b = !a_req;
`else
                win_b = !a_req || (b_req && !last_winner_b);
`endif
                c = win_b ? b_q[0] : a_q[0];
                if (win_b) eb_gnt = 1'b1; else ea_gnt = 1'b1;
                last_winner_b = win_b;
                exp_ram_adr   = c.adr;
                exp_ram_data  = c.data;
                if (c.we) begin
                    ref_mem[c.adr] = c.data;
                    e_en        = 1'b1;
                    next_sample = cyc + 2;
                end else begin
                    rv_at       = cyc + 2;
                    rv_b        = win_b;
                    rv_data     = ref_mem[c.adr];
                    next_sample = cyc + 3;
                end
            end
            if (cyc == rv_at) begin
                if (rv_b) begin eb_rv = 1'b1; exp_b_rdata = rv_data; end
                else      begin ea_rv = 1'b1; exp_a_rdata = rv_data; end
            end
            e_busy = (cyc + 1 < next_sample);

            got  = outs();
            expv = {ea_gnt, eb_gnt, ea_rv, eb_rv, e_en, e_busy,
                    exp_ram_adr, exp_ram_data, exp_a_rdata, exp_b_rdata};
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL cycle_outputs @%0d: got %h expected %h (gnt a/b, rvalid a/b, en, busy, adr, data, rdata a/b)",
                         cyc, got, expv);
            end

            if (a_gnt) begin gnt_log.push_back(0); a_gnt_cnt++; end
            if (b_gnt) gnt_log.push_back(1);
            if (a_rvalid) rd_log.push_back(a_rdata);
            if (b_rvalid) rd_log.push_back(b_rdata);

            if (ea_gnt) void'(a_q.pop_front());
            if (eb_gnt) void'(b_q.pop_front());

            if (cyc - start >= rnd_cycles && a_q.size() == 0 && b_q.size() == 0 &&
                cyc >= rv_at && cyc + 1 >= next_sample) begin
                done = 1'b1;
            end else if (cyc - start >= max_cycles) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout @%0d: got still busy after %0d cycles, required drain", cyc, max_cycles);
                a_q.delete();
                b_q.delete();
                done = 1'b1;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rd_log.delete();
        a_gnt_cnt = 0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk); #1; cyc++;
        n_checks++;
        if (outs() !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs());
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        @(posedge clk); #1; cyc++;
        n_checks++;
        if (outs() !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h required 0", outs());
        end
        @(posedge clk); #1; cyc++;
        n_checks++;
        if (outs() !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h required 0", outs());
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_a_writes();
        clear_logs();
        for (int i = 0; i < 4; i++) a_q.push_back(mk(1'b1, i, i + 1));
        run(60, 0);
        n_checks++;
        if (a_gnt_cnt != 4 || gnt_log.size() != 4) begin
            n_fail++;
            $display("FAIL a_writes_grants: got a=%0d total=%0d required a=4 total=4", a_gnt_cnt, gnt_log.size());
        end
    endtask

    task automatic test_b_reads();
        logic [DW-1:0] want [4] = '{8'h03, 8'h02, 8'h04, 8'h01};
        int            adrs [4] = '{2, 1, 3, 0};
        clear_logs();
        for (int i = 0; i < 4; i++) b_q.push_back(mk(1'b0, adrs[i], 0));
        run(60, 0);
        n_checks++;
        if (rd_log.size() != 4) begin
            n_fail++;
            $display("FAIL b_reads_count: got %0d required 4", rd_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rd_log[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL b_reads_data[%0d]: got %h required %h", i, rd_log[i], want[i]);
                end
            end
        end
        n_checks++;
        if (a_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL b_reads_a_rdata_held: got %h required 00", a_rdata);
        end
    endtask

    task automatic test_contention();
        int order [4];
`ifdef ARB_FIXED_PRIO_EN
        order = '{0, 0, 1, 1};
`else
        order = '{0, 1, 0, 1};
`endif
        do_reset();
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            a_q.push_back(mk(1'b1, 63, 8'hAA));
            b_q.push_back(mk(1'b0, 63, 0));
        end
        run(60, 0);
        n_checks++;
        if (gnt_log.size() != 4) begin
            n_fail++;
            $display("FAIL contention_count: got %0d required 4", gnt_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (gnt_log[i] != order[i]) begin
                    n_fail++;
                    $display("FAIL contention_order[%0d]: got %0d required %0d (0=A 1=B)", i, gnt_log[i], order[i]);
                end
            end
        end
        n_checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 8'hAA || rd_log[1] !== 8'hAA) begin
            n_fail++;
            $display("FAIL contention_read: got %0d reads first %h required 2 reads of aa",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'h00);
        end
    endtask

    task automatic test_handshake();
        clear_logs();
        a_q.push_back(mk(1'b1, 20, 8'h11));
        a_q.push_back(mk(1'b1, 20, 8'h22));
        a_q.push_back(mk(1'b0, 20, 0));
        run(60, 0);
        n_checks++;
        if (a_gnt_cnt != 3) begin
            n_fail++;
            $display("FAIL handshake_grants: got %0d required 3", a_gnt_cnt);
        end
        n_checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 8'h22) begin
            n_fail++;
            $display("FAIL handshake_final_data: got %0d reads first %h required 1 read of 22",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'h00);
        end
    endtask

    task automatic test_reset_mid_issue();
        a_q.push_back(mk(1'b1, 10, 8'h55));
        run(40, 0);
        a_req = 1'b1; a_we = 1'b1; a_adr = AW'(10); a_data = 8'h99; b_req = 1'b0;
        @(posedge clk); #1; cyc++;
        n_checks++;
        if ({a_gnt, ram_en, busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_issue_entry: got gnt/en/busy %b required 111", {a_gnt, ram_en, busy});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 36'h0) begin
            n_fail++;
            $display("FAIL mid_issue_async_reset: got %h required 0", outs());
        end
        a_req = 1'b0;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        model_reset();
        clear_logs();
        a_q.push_back(mk(1'b0, 10, 0));
        run(40, 0);
        n_checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 8'h55) begin
            n_fail++;
            $display("FAIL mid_issue_write_lost: got %0d reads first %h required 1 read of 55",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        do_reset();
        clear_logs();
        run(4000, 1500);
    endtask

    initial begin
        test_reset();
        test_a_writes();
        test_b_reads();
        test_contention();
        test_handshake();
        test_reset_mid_issue();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1ms, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/single_port_ram_arbiter.md
Name: single_port_ram_arbiter

Overview:
Two-requester arbiter and sequencer in front of one single_port_ram instance (8-bit data, 6-bit address, en=1 write / en=0 read). Accepts read/write commands from requesters A and B, serialises them onto the single RAM port with round-robin fairness, and returns read data with a valid pulse. Sits between client logic (e.g. DMA and CPU-side ports) and the RAM macro; the RAM itself is unchanged.

Parameters:
DATA_W, 8, RAM data width
ADDR_W, 6, RAM address width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
a_req  input  1  requester A command request; hold until a_gnt
a_we  input  1  A command type: 1 write, 0 read
a_adr  input  ADDR_W  A address
a_data  input  DATA_W  A write data
a_gnt  output  1  one-cycle pulse: A command accepted and issued
a_rvalid  output  1  one-cycle pulse: a_rdata valid
a_rdata  output  DATA_W  A read data, held until next A read completes
b_req, b_we, b_adr, b_data, b_gnt, b_rvalid, b_rdata: same as A, for requester B
ram_en  output  1  to RAM en (1 = write this edge)
ram_adr  output  ADDR_W  to RAM adr
ram_data  output  DATA_W  to RAM data
ram_out  input  DATA_W  from RAM out, valid the cycle after a read is issued
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock clk, reset rst: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0 (gnt, rvalid, rdata, ram_en, ram_adr, ram_data, busy); state IDLE; round-robin pointer = "last granted B" (A wins first tie).
- FSM states: IDLE, ISSUE, RESP. All outputs registered.
- IDLE: req sampled. None -> stay IDLE, ram_en=0. One -> that requester wins. Both -> requester not granted last wins. Winner's we/adr/data latched into ram_en/ram_adr/ram_data; winner's gnt=1 next cycle; pointer updated; -> ISSUE.
- ISSUE (1 cycle): ram_* stable, x_gnt high. RAM writes (ram_en=1) or reads on the edge ending this cycle. Write -> IDLE with ram_en cleared. Read -> RESP.
- RESP (1 cycle): ram_out captured into winner's x_rdata; x_rvalid pulses 1 cycle after entry; ram_en=0; -> IDLE.
- Latencies from first req-high edge in IDLE: gnt +1 cycle; write complete at end of gnt cycle; rvalid +3 cycles. Write throughput one per 2 cycles; read one per 3 cycles.
- Requester must drop req (or present a new command) in the cycle its gnt is high. Req is sampled only in IDLE, so a held req in the gnt cycle is not double-accepted; req still high when next sampled in IDLE is a new command.
- Loser's req ignored while busy; loser's command must stay stable until its gnt.
- Idle default: ram_en=0, ram_adr/ram_data hold last values; no spurious writes.
- rdata of the non-winning requester never changes.
- Reset asserted mid-operation: state -> IDLE immediately; pending write may be lost if rst precedes the ISSUE-ending edge; no rvalid issued for the aborted read; pointer reset.
- Address/data pass through unmodified; no arithmetic; full address range 0..2^ADDR_W-1 legal.

Optional Feature:
ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority; A always wins when both request and the round-robin pointer is removed. When undefined (default), round-robin as above. All timing is identical in both builds.

Test Plan:
- Reset: rst=1 mid-ISSUE of a write -> all outputs 0 within the same cycle; after release, a single A read returns the pre-reset RAM content, with no rvalid for the aborted command.
- A-only writes: A writes 0x01..0x04 to addresses 0..3 -> a_gnt pulses +1 cycle after each acceptance; ram_en=1 only in the ISSUE cycles; b_gnt stays 0.
- B-only reads: B reads addresses 2,1,3,0 after the writes above -> b_rvalid with b_rdata 0x03,0x02,0x04,0x01, each 3 cycles after acceptance; a_rdata unchanged.
- Contention: A and B both request continuously (A write 0x3F<-0xAA, B read 0x3F) -> grants alternate A,B,A,B starting with A after reset; B read returns 0xAA.
- Handshake: A holds req high through its gnt cycle with a new command -> exactly one new gnt per IDLE sample, no duplicate write of the old command.
- ARB_FIXED_PRIO_EN build: both requesting continuously -> A granted every time and B starved; B is granted only when a_req=0.
